// File: rtl/clip_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clip_engine: multi-clip record/playback sequencer over one memory port.    |
// | Optional: CLIP_ENGINE_LOOP_EN makes playback wrap to the clip start.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clip_engine #(
    parameter int WORD_LENGTH = 16,
    parameter int NUM_CLIPS   = 4,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   play_command_i,
    input  logic                                   record_command_i,
    input  logic [$clog2(NUM_CLIPS)-1:0]           play_clip_select_i,
    input  logic [$clog2(NUM_CLIPS)-1:0]           record_clip_select_i,
    input  logic                                   sample_in_valid_i,
    input  logic [WORD_LENGTH-1:0]                 sample_in_i,
    input  logic                                   sample_out_req_i,
    output logic [WORD_LENGTH-1:0]                 sample_out_o,
    output logic                                   serializer_enable_o,
    output logic                                   deserializer_enable_o,
    output logic                                   mem_en_o,
    output logic                                   mem_we_o,
    output logic [$clog2(NUM_CLIPS)+ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORD_LENGTH-1:0]                 mem_wdata_o,
    input  logic [WORD_LENGTH-1:0]                 mem_rdata_i,
    output logic [1:0]                             state_o,
    output logic [3:0]                             play_clip_o,
    output logic [3:0]                             record_clip_o
);

    localparam int CLIP_WIDTH = $clog2(NUM_CLIPS);
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECORD = 2'd1;
    localparam logic [1:0] S_PRIME  = 2'd2;
    localparam logic [1:0] S_PLAY   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   play_cmd_q, play_cmd_d;
    logic                   rec_cmd_q, rec_cmd_d;
    logic [CLIP_WIDTH-1:0]  play_clip_q, play_clip_d;
    logic [CLIP_WIDTH-1:0]  rec_clip_q, rec_clip_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEN_WIDTH-1:0]   len_q [NUM_CLIPS];
    logic [LEN_WIDTH-1:0]   len_d [NUM_CLIPS];
    logic                   rd_pending_q, rd_pending_d;
    logic [WORD_LENGTH-1:0] sample_out_q, sample_out_d;

    logic                   w_play_edge;
    logic                   w_rec_edge;
    logic [LEN_WIDTH-1:0]   w_sel_len;
    logic [LEN_WIDTH-1:0]   w_play_len;
    logic [LEN_WIDTH-1:0]   w_wr_count;
    logic [LEN_WIDTH-1:0]   w_rd_next;
    logic                   w_mem_en;
    logic                   w_mem_we;
    logic [CLIP_WIDTH+ADDR_WIDTH-1:0] w_mem_addr;

    always_comb begin
        w_play_edge = play_command_i & ~play_cmd_q;
        w_rec_edge  = record_command_i & ~rec_cmd_q;
        w_sel_len   = '0;
        w_play_len  = '0;
        for (int c = 0; c < NUM_CLIPS; c++) begin
            if (play_clip_select_i == CLIP_WIDTH'(c)) w_sel_len = len_q[c];
            if (play_clip_q == CLIP_WIDTH'(c))        w_play_len = len_q[c];
        end
        // Samples written so far, counting one strobed this very cycle.
        w_wr_count = {1'b0, wr_ptr_q} + LEN_WIDTH'(sample_in_valid_i);
        w_rd_next  = {1'b0, rd_ptr_q} + LEN_WIDTH'(1);
    end

    always_comb begin
        state_d      = state_q;
        play_cmd_d   = play_command_i;
        rec_cmd_d    = record_command_i;
        play_clip_d  = play_clip_q;
        rec_clip_d   = rec_clip_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        rd_pending_d = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;

        case (state_q)
            S_IDLE: begin
                if (w_rec_edge) begin
                    state_d    = S_RECORD;
                    wr_ptr_d   = '0;
                    rec_clip_d = record_clip_select_i;
                end else if (w_play_edge && (w_sel_len != '0)) begin
                    state_d     = S_PRIME;
                    rd_ptr_d    = '0;
                    play_clip_d = play_clip_select_i;
                end
            end
            S_RECORD: begin
                if (sample_in_valid_i) begin
                    w_mem_en   = 1'b1;
                    w_mem_we   = 1'b1;
                    w_mem_addr = {rec_clip_q, wr_ptr_q};
                    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
                end
                if (w_rec_edge || (sample_in_valid_i && (wr_ptr_q == {ADDR_WIDTH{1'b1}}))) begin
                    for (int c = 0; c < NUM_CLIPS; c++) begin
                        if (rec_clip_q == CLIP_WIDTH'(c)) len_d[c] = w_wr_count;
                    end
                    state_d = S_IDLE;
                end
            end
            S_PRIME: begin
                w_mem_en     = 1'b1;
                w_mem_addr   = {play_clip_q, {ADDR_WIDTH{1'b0}}};
                rd_pending_d = 1'b1;
                state_d      = S_PLAY;
            end
            S_PLAY: begin
                if (w_play_edge) begin
                    state_d = S_IDLE;
                end else if (sample_out_req_i) begin
                    if (w_rd_next < w_play_len) begin
                        w_mem_en     = 1'b1;
                        w_mem_addr   = {play_clip_q, w_rd_next[ADDR_WIDTH-1:0]};
                        rd_pending_d = 1'b1;
                        rd_ptr_d     = w_rd_next[ADDR_WIDTH-1:0];
                    end else begin
`ifdef CLIP_ENGINE_LOOP_EN
                        w_mem_en     = 1'b1;
                        w_mem_addr   = {play_clip_q, {ADDR_WIDTH{1'b0}}};
                        rd_pending_d = 1'b1;
                        rd_ptr_d     = '0;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Memory returns data one cycle after the issue; capture it then.
        sample_out_d = rd_pending_q ? mem_rdata_i : sample_out_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            play_cmd_q   <= 1'b0;
            rec_cmd_q    <= 1'b0;
            play_clip_q  <= '0;
            rec_clip_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= 1'b0;
            sample_out_q <= '0;
            for (int c = 0; c < NUM_CLIPS; c++) len_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            play_cmd_q   <= play_cmd_d;
            rec_cmd_q    <= rec_cmd_d;
            play_clip_q  <= play_clip_d;
            rec_clip_q   <= rec_clip_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;
            sample_out_q <= sample_out_d;
            for (int c = 0; c < NUM_CLIPS; c++) len_q[c] <= len_d[c];
        end
    end

    assign sample_out_o          = sample_out_q;
    assign serializer_enable_o   = (state_q == S_PLAY);
    assign deserializer_enable_o = (state_q == S_RECORD);
    assign mem_en_o              = w_mem_en;
    assign mem_we_o              = w_mem_we;
    assign mem_addr_o            = w_mem_addr;
    assign mem_wdata_o           = sample_in_i;
    assign state_o               = state_q;
    assign play_clip_o           = 4'(play_clip_q);
    assign record_clip_o         = 4'(rec_clip_q);

endmodule
`default_nettype wire
